// File: rtl/serial_adder.sv
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial WIDTH-bit adder around a 1-bit full-adder cell, LSB first.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic S,
   output logic co
);
   assign S  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_a_sh;
   logic [WIDTH-1:0]   r_b_sh;
   logic [WIDTH-2:0]   r_res_sh;
   logic [WIDTH-1:0]   r_sum;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_carry;
   logic               r_co;
   logic               r_busy;
   logic               r_done;
   logic               w_s;
   logic               w_co_cell;
   logic               w_last;
   logic [WIDTH-1:0]   w_res_next;

   adder u_fa (
      .a  (r_a_sh[0]),
      .b  (r_b_sh[0]),
      .ci (r_carry),
      .S  (w_s),
      .co (w_co_cell)
   );

   // Only the upper WIDTH-1 result bits survive a shift, so the holding
   // register drops the bit that would fall off the bottom.
   assign w_res_next = {w_s, r_res_sh};
   assign w_last     = (r_cnt == c_last);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = SHIFT;
         SHIFT:   if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_a_sh   <= '0;
         r_b_sh   <= '0;
         r_res_sh <= '0;
         r_sum    <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_co     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // Handshake flags are registered from the current state, one cycle behind it.
         r_busy  <= (r_state != IDLE);
         r_done  <= (r_state == DONE);
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a_sh   <= a;
                  r_b_sh   <= b;
                  r_carry  <= ci;
                  r_res_sh <= '0;
                  r_cnt    <= '0;
               end
            end
            SHIFT: begin
               r_res_sh <= w_res_next[WIDTH-1:1];
               r_a_sh   <= r_a_sh >> 1;
               r_b_sh   <= r_b_sh >> 1;
               r_carry  <= w_co_cell;
               r_cnt    <= r_cnt + 1'b1;
               if (w_last) begin
                  r_sum <= w_res_next;
                  r_co  <= w_co_cell;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign co   = r_co;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_adder;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start8 = 1'b0, ci8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8, co8;
   logic [7:0] sum8;
   logic       start4 = 1'b0, ci4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4, co4;
   logic [3:0] sum4;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
      .busy(busy8), .done(done8), .sum(sum8), .co(co8)
   );

   serial_adder #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .ci(ci4),
      .busy(busy4), .done(done4), .sum(sum4), .co(co4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
   endtask

   // One rising edge, then settle at the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
      a8 = a; b8 = b; ci8 = c; start8 = 1'b1;
      tick();
      start8 = 1'b0;
   endtask

   task automatic wait_done8(output int lat);
      lat = 0;
      while (!done8 && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat;

      // Reset state
      repeat (3) tick();
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_sum",  32'(sum8),  32'd0);
      chk("rst_co",   32'(co8),   32'd0);
      rst = 1'b0;
      tick();

      // 1: 0+0, busy/done timing relative to the accepting edge
      start_op8(8'h00, 8'h00, 1'b0);
      chk("t1_bd_e0", 32'({busy8, done8}), 32'd0);
      for (int e = 1; e <= 10; e++) begin
         tick();
         chk($sformatf("t1_bd_e%0d", e), 32'({busy8, done8}), 32'({(e <= 9), (e == 9)}));
      end
      chk("t1_sum", 32'(sum8), 32'h00);
      chk("t1_co",  32'(co8),  32'd0);

      // 2: carry out of the top bit, then carry ripple into the MSB
      start_op8(8'hFF, 8'h01, 1'b0);
      wait_done8(lat);
      chk("t2a_lat", 32'(lat), 32'd9);
      chk("t2a_sum", 32'(sum8), 32'h00);
      chk("t2a_co",  32'(co8),  32'd1);
      tick();
      start_op8(8'h7F, 8'h01, 1'b0);
      wait_done8(lat);
      chk("t2b_lat", 32'(lat), 32'd9);
      chk("t2b_sum", 32'(sum8), 32'h80);
      chk("t2b_co",  32'(co8),  32'd0);
      tick();

      // 3: A5+5A+1; previous result must hold until the final shift edge
      start_op8(8'hA5, 8'h5A, 1'b1);
      for (int e = 1; e <= 9; e++) begin
         tick();
         chk($sformatf("t3_sum_e%0d", e), 32'(sum8), (e < 8) ? 32'h80 : 32'h00);
         chk($sformatf("t3_co_e%0d", e),  32'(co8),  (e < 8) ? 32'd0 : 32'd1);
      end
      chk("t3_done", 32'(done8), 32'd1);
      tick();

      // 4: start held high, operand A changed mid-flight
      a8 = 8'h03; b8 = 8'h04; ci8 = 1'b0; start8 = 1'b1;
      tick();
      for (int e = 1; e <= 29; e++) begin
         if (e == 3) a8 = 8'hFF;
         tick();
         chk($sformatf("t4_done_e%0d", e), 32'(done8), 32'((e % 10) == 9));
         if (e == 9) begin
            chk("t4_sum1", 32'(sum8), 32'h07);
            chk("t4_co1",  32'(co8),  32'd0);
         end
         if (e == 19) begin
            chk("t4_sum2", 32'(sum8), 32'h03);
            chk("t4_co2",  32'(co8),  32'd1);
         end
      end
      start8 = 1'b0;
      tick();
      chk("t4_idle_busy", 32'(busy8), 32'd0);

      // 5: reset on the 4th shift edge aborts the add
      start_op8(8'hFF, 8'hFF, 1'b0);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_busy", 32'(busy8), 32'd0);
      chk("t5_done", 32'(done8), 32'd0);
      chk("t5_sum",  32'(sum8),  32'h00);
      chk("t5_co",   32'(co8),   32'd0);
      tick();
      chk("t5_nodone", 32'(done8), 32'd0);
      start_op8(8'hFF, 8'hFF, 1'b0);
      wait_done8(lat);
      chk("t5_lat", 32'(lat), 32'd9);
      chk("t5_sum2", 32'(sum8), 32'hFE);
      chk("t5_co2",  32'(co8),  32'd1);
      tick();
      chk("t5_done_once", 32'(done8), 32'd0);

      // 6: WIDTH=4 exhaustive sweep
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               a4 = 4'(a); b4 = 4'(b); ci4 = 1'(c); start4 = 1'b1;
               tick();
               start4 = 1'b0;
               lat = 0;
               while (!done4 && lat < 20) begin
                  tick();
                  lat++;
               end
               chk($sformatf("t6_lat_%0d_%0d_%0d", a, b, c), 32'(lat), 32'd5);
               chk($sformatf("t6_res_%0d_%0d_%0d", a, b, c), 32'({co4, sum4}), 32'(a + b + c));
               tick();
               chk($sformatf("t6_single_%0d_%0d_%0d", a, b, c), 32'(done4), 32'd0);
            end
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial multi-bit adder built around the existing 1-bit full-adder cell `adder` (ports a, b, ci, S, co). Feeds the cell one operand bit pair per clock, LSB first. Registers the cell's carry-out back into its carry-in. Shifts the cell's sum bit into a result register. Sits directly downstream of and around the full-adder cell and gives the datapath a WIDTH-bit add with a start/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range >= 2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  request a new add; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
ci  input  1  initial carry-in; captured on the accepted start edge
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse; sum and co are valid
sum  output  WIDTH  result register; holds until the next result
co  output  1  final carry-out; holds until the next result

Behaviour:
- Reset: on the rst=1 clock edge, all state is cleared; rst has priority over all other inputs.
  - state=IDLE, cnt=0, internal shift registers=0, carry=0.
  - busy=0, done=0, sum=0, co=0.
  - rst asserted during SHIFT or DONE aborts the operation; no done pulse; sum and co are cleared to 0.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1: a_sh<=a, b_sh<=b, carry<=ci, res_sh<=0, cnt<=0, state<=SHIFT.
- SHIFT (busy=1):
  - Full-adder cell inputs are a_sh[0], b_sh[0], carry.
  - Each edge: res_sh<={S, res_sh[WIDTH-1:1]}, a_sh>>=1, b_sh>>=1, carry<=co_cell, cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (WIDTH-th bit), additionally: sum<={S, res_sh[WIDTH-1:1]}, co<=co_cell, state<=DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle.
  - Next edge: state<=IDLE.
  - start is ignored in DONE.
- Latency: start sampled at edge k; done is high in the cycle after edge k+WIDTH+1. Minimum start-to-start period is WIDTH+2 cycles.
- start during SHIFT or DONE is ignored and has no effect on the operation in flight; a, b, ci may change freely after capture.
- sum and co change only on the final SHIFT edge or on reset; they are stable in IDLE.
- Arithmetic is modulo 2^WIDTH. {co,sum} == a + b + ci exactly (WIDTH+1-bit result).
- done and busy are registered outputs (no combinational path from start).
- cnt is $clog2(WIDTH) bits wide; no wrap beyond WIDTH-1 is reachable.

Test Plan:
1. WIDTH=8, a=0x00, b=0x00, ci=0, start at edge 0 -> busy=1 from edge 1; done=1 only in the cycle after edge 9; sum=0x00, co=0.
2. a=0xFF, b=0x01, ci=0 -> sum=0x00, co=1. Then a=0x7F, b=0x01, ci=0 -> sum=0x80, co=0 (carry ripples through all bits).
3. a=0xA5, b=0x5A, ci=1 -> sum=0x00, co=1. Check that the previous sum holds through the whole SHIFT phase until the final edge.
4. start=1 held continuously with a=0x03, b=0x04 changed to a=0xFF mid-SHIFT -> exactly one done per 10 cycles; first result sum=0x07, co=0.
5. rst=1 on the 4th SHIFT edge of a=0xFF+b=0xFF -> next cycle busy=0, done=0, sum=0x00, co=0. A new start afterwards completes normally with sum=0xFE, co=1 for the same operands.
6. WIDTH=4, exhaustive sweep of all 512 (a,b,ci) combinations -> every done pulse has {co,sum}==a+b+ci; no missed or extra done pulses.
